instr_sequencer: RTL and testbench
==================================

// Module: instr_sequencer
// PURPOSE
//  Autonomous instruction issuer for the multi-cycle processor. Holds a small
//  program RAM, fetches 24-bit instructions at a PC, presents each on the
//  processor's func/new_func interface, waits for proc_done, then advances.
//  Resolves ldpc (supplies pc) and branch (loads PC from branch_target).
// PARAMETERS
//  ADDR_W   4    program RAM address width; depth = 2**ADDR_W words
//  TIMEOUT  32   max cycles WAIT may last before error (>=2)
// PORTS
//  clk            in   1       rising-edge clock
//  reset          in   1       asynchronous, active-high reset
//  prog_we        in   1       program write strobe (honoured in IDLE only)
//  prog_addr      in   ADDR_W  program write address
//  prog_wdata     in   24      program write data {op[23:20],rd[19:16],imm/rs}
//  run            in   1       level: 1 = execute program, 0 = stop at boundary
//  proc_done      in   1       1-cycle pulse from processor: instruction retired
//  branch_target  in   16      processor bus value; [ADDR_W-1:0] used on branch
//  func           out  24      instruction to processor
//  new_func       out  1       1-cycle issue strobe
//  proc_start     out  1       processor enable
//  pc             out  ADDR_W  current program counter (read by ldpc)
//  busy           out  1       1 in FETCH/ISSUE/WAIT
//  halted         out  1       1 in HALT
//  error          out  1       sticky: WAIT timeout occurred
//  retired        out  16      count of retired instructions, saturating
// BEHAVIOUR
//  Reset: state=IDLE, pc=0, func=0, new_func=0, proc_start=0, busy=0,
//   halted=0, error=0, retired=0, timer=0. RAM contents not reset.
//  States: IDLE, FETCH, ISSUE, WAIT, HALT.
//  IDLE: prog_we writes RAM[prog_addr]. run=1 -> FETCH, proc_start<=1.
//   prog_we ignored in every other state.
//  FETCH: synchronous RAM read of RAM[pc]; 1 cycle -> ISSUE.
//  ISSUE: func<=RAM data. If op==4'hF (halt): no strobe, -> HALT.
//   Else new_func=1 for exactly this cycle, timer<=0, -> WAIT.
//  WAIT: func held stable, new_func=0, timer+1 each cycle.
//   proc_done=1: retired+1 (saturate at 16'hFFFF);
//    op==4'h6 (branch): pc<=branch_target[ADDR_W-1:0]; else pc<=pc+1,
//    wrapping 2**ADDR_W-1 -> 0. Then run=1 -> FETCH, run=0 -> IDLE.
//   timer reaches TIMEOUT-1 without proc_done: error<=1, -> HALT, pc held.
//   proc_done on the timeout cycle: done wins, no error.
//  HALT: proc_start<=0, halted=1. run=0 -> IDLE (halted<=0). error cleared
//   only by reset.
//  run dropping in FETCH/ISSUE: current instruction still issued and
//   completed; IDLE entered after its proc_done (no abandoned instruction).
//  proc_done outside WAIT: ignored.
//  Issue-to-issue minimum latency: ISSUE, WAIT(>=1), FETCH -> 3 cycles.
//  pc during ldpc equals the address of the ldpc instruction itself.
//  Reset mid-WAIT: immediate return to IDLE, new_func/proc_start low same
//   instant; processor is reset together with this block.
// TESTING
//  Load 0:{0,0,0010},1:{0,1,0004},2:{2,0,1,000},3:{F..}; run=1, done 2 cyc
//   after each strobe -> 3 new_func pulses, func matches RAM, retired=3, HALT.
//  Program with branch at addr 4, branch_target=16'h0001 -> next fetch addr
//   1; pc=1 visible while the addr-1 instruction is issued.
//  ADDR_W=4, fill 0..15 non-halt, no halt -> pc wraps 15->0, fetch RAM[0].
//  Withhold proc_done for TIMEOUT cycles -> error=1, halted=1, pc unchanged;
//   done on the final cycle instead -> no error.
//  Drop run during WAIT -> instruction completes, IDLE after proc_done; raise
//   run -> resumes at pc+1.
//  Assert reset mid-WAIT and prog_we while busy -> all outputs to reset
//   values at once; RAM unchanged by the ignored write.

Source files
------------

// File: rtl/instr_sequencer.sv
// Autonomous instruction issuer: fetches 24-bit words from a small program RAM,
// issues each to the multi-cycle processor and advances on proc_done.
module instr_sequencer #(
    parameter int ADDR_W  = 4,
    parameter int TIMEOUT = 32
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              prog_we,
    input  logic [ADDR_W-1:0] prog_addr,
    input  logic [23:0]       prog_wdata,
    input  logic              run,
    input  logic              proc_done,
    input  logic [15:0]       branch_target,
    output logic [23:0]       func,
    output logic              new_func,
    output logic              proc_start,
    output logic [ADDR_W-1:0] pc,
    output logic              busy,
    output logic              halted,
    output logic              error,
    output logic [15:0]       retired,
    output logic [2:0]        state_dbg
);

    localparam int            DEPTH      = 2 ** ADDR_W;
    localparam int            TW         = $clog2(TIMEOUT);
    localparam logic [TW-1:0] TIMER_LAST = TW'(TIMEOUT - 1);
    localparam logic [3:0]    OP_BRANCH  = 4'h6;
    localparam logic [3:0]    OP_HALT    = 4'hF;

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_FETCH = 3'd1,
        S_ISSUE = 3'd2,
        S_WAIT  = 3'd3,
        S_HALT  = 3'd4
    } state_t;

    state_t        state;
    state_t        state_next;
    logic [23:0]   mem [DEPTH];
    logic [TW-1:0] timer;

    // Handshake: new_func is high for exactly the one ISSUE cycle while func
    // carries the instruction; func then stays stable until the processor
    // answers with a single-cycle proc_done, which is only honoured in WAIT.
    always_comb begin
        state_next = state;
        new_func   = 1'b0;
        case (state)
            S_IDLE:  if (run) state_next = S_FETCH;
            S_FETCH: state_next = S_ISSUE;
            S_ISSUE: begin
                if (func[23:20] == OP_HALT) begin
                    state_next = S_HALT;
                end else begin
                    new_func   = 1'b1;
                    state_next = S_WAIT;
                end
            end
            S_WAIT: begin
                if (proc_done)                state_next = run ? S_FETCH : S_IDLE;
                else if (timer == TIMER_LAST) state_next = S_HALT;
            end
            S_HALT:  if (!run) state_next = S_IDLE;
            default: state_next = S_IDLE;
        endcase
    end

    assign busy      = (state == S_FETCH) || (state == S_ISSUE) || (state == S_WAIT);
    assign halted    = (state == S_HALT);
    assign state_dbg = state;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) state <= S_IDLE;
        else       state <= state_next;
    end

    // Program RAM is not reset; loading is only allowed while idle.
    always_ff @(posedge clk) begin
        if (prog_we && (state == S_IDLE)) mem[prog_addr] <= prog_wdata;
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            func       <= '0;
            pc         <= '0;
            proc_start <= 1'b0;
            error      <= 1'b0;
            retired    <= '0;
            timer      <= '0;
        end else begin
            case (state)
                S_IDLE:  if (run) proc_start <= 1'b1;
                S_FETCH: func <= mem[pc];
                S_ISSUE: timer <= '0;
                S_WAIT: begin
                    // A done arriving on the last allowed cycle beats the timeout.
                    if (proc_done) begin
                        if (retired != 16'hFFFF) retired <= retired + 16'd1;
                        if (func[23:20] == OP_BRANCH) pc <= branch_target[ADDR_W-1:0];
                        else                          pc <= pc + 1'b1;
                    end else if (timer == TIMER_LAST) begin
                        error <= 1'b1;
                    end else begin
                        timer <= timer + 1'b1;
                    end
                end
                S_HALT:  proc_start <= 1'b0;
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_instr_sequencer.sv
// Directed bench for instr_sequencer: a processor responder answers each issue
// with proc_done after a programmable delay; tasks check results inline.
module tb_instr_sequencer;

    localparam int ADDR_W  = 4;
    localparam int TIMEOUT = 32;

    logic              clk = 1'b0;
    logic              reset = 1'b1;
    logic              prog_we = 1'b0;
    logic [ADDR_W-1:0] prog_addr = '0;
    logic [23:0]       prog_wdata = '0;
    logic              run = 1'b0;
    logic              man_done = 1'b0;
    logic              resp_done = 1'b0;
    logic              proc_done;
    logic [15:0]       branch_target = 16'h0000;
    logic [23:0]       func;
    logic              new_func;
    logic              proc_start;
    logic [ADDR_W-1:0] pc;
    logic              busy;
    logic              halted;
    logic              error;
    logic [15:0]       retired;
    logic [2:0]        state_dbg;

    assign proc_done = man_done | resp_done;

    instr_sequencer #(.ADDR_W(ADDR_W), .TIMEOUT(TIMEOUT)) dut (
        .clk(clk), .reset(reset), .prog_we(prog_we), .prog_addr(prog_addr),
        .prog_wdata(prog_wdata), .run(run), .proc_done(proc_done),
        .branch_target(branch_target), .func(func), .new_func(new_func),
        .proc_start(proc_start), .pc(pc), .busy(busy), .halted(halted),
        .error(error), .retired(retired), .state_dbg(state_dbg)
    );

    // clock / reset
    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int n_cmp  = 0;
    int n_fail = 0;

    logic [23:0]       exp_q[$];
    logic [23:0]       obs_q[$];
    logic [ADDR_W-1:0] obs_pc_q[$];
    int                obs_t_q[$];
    int                resp_delay = 2;
    bit                resp_en = 1'b0;

    // processor model: record every issue, answer after resp_delay cycles
    initial begin
        forever begin
            @(negedge clk);
            if (new_func === 1'b1) begin
                obs_q.push_back(func);
                obs_pc_q.push_back(pc);
                obs_t_q.push_back(cyc);
                if (resp_en) begin
                    repeat (resp_delay) @(posedge clk);
                    #1 resp_done = 1'b1;
                    @(posedge clk);
                    #1 resp_done = 1'b0;
                end
            end
        end
    end

    // driver tasks
    task automatic apply_reset();
        run = 1'b0; prog_we = 1'b0; man_done = 1'b0; resp_en = 1'b0;
        reset = 1'b1;
        repeat (2) @(posedge clk);
        @(negedge clk);
        reset = 1'b0;
        obs_q.delete(); obs_pc_q.delete(); obs_t_q.delete(); exp_q.delete();
    endtask

    task automatic load_word(input logic [ADDR_W-1:0] a, input logic [23:0] d);
        @(negedge clk);
        prog_we = 1'b1; prog_addr = a; prog_wdata = d;
        @(negedge clk);
        prog_we = 1'b0;
    endtask

    task automatic wait_halted(input string name, input int bound);
        int n = 0;
        while (halted !== 1'b1 && n < bound) begin @(negedge clk); n++; end
        n_cmp++; if (halted !== 1'b1) begin n_fail++; $display("FAIL %s_halt_wait: halted=%b after %0d cycles, expected 1", name, halted, bound); end
    endtask

    task automatic wait_idle(input string name, input int bound);
        int n = 0;
        while (busy !== 1'b0 && n < bound) begin @(negedge clk); n++; end
        n_cmp++; if (busy !== 1'b0) begin n_fail++; $display("FAIL %s_idle_wait: busy=%b after %0d cycles, expected 0", name, busy, bound); end
    endtask

    task automatic wait_obs(input string name, input int count, input int bound);
        int n = 0;
        while (obs_q.size() < count && n < bound) begin @(negedge clk); n++; end
        n_cmp++; if (obs_q.size() < count) begin n_fail++; $display("FAIL %s_obs_wait: %0d issues seen, expected %0d", name, obs_q.size(), count); end
    endtask

    task automatic wait_new_func(input string name, input int bound);
        int n = 0;
        @(negedge clk);
        while (new_func !== 1'b1 && n < bound) begin @(negedge clk); n++; end
        n_cmp++; if (new_func !== 1'b1) begin n_fail++; $display("FAIL %s_issue_wait: new_func=%b, expected 1", name, new_func); end
    endtask

    task automatic test_reset();
        reset = 1'b1;
        @(negedge clk);
        n_cmp++; if (func !== 24'h0) begin n_fail++; $display("FAIL rst_func: got %h expected 000000", func); end
        n_cmp++; if (new_func !== 1'b0) begin n_fail++; $display("FAIL rst_new_func: got %b expected 0", new_func); end
        n_cmp++; if (proc_start !== 1'b0) begin n_fail++; $display("FAIL rst_proc_start: got %b expected 0", proc_start); end
        n_cmp++; if (pc !== 4'd0) begin n_fail++; $display("FAIL rst_pc: got %0d expected 0", pc); end
        n_cmp++; if (busy !== 1'b0) begin n_fail++; $display("FAIL rst_busy: got %b expected 0", busy); end
        n_cmp++; if (halted !== 1'b0) begin n_fail++; $display("FAIL rst_halted: got %b expected 0", halted); end
        n_cmp++; if (error !== 1'b0) begin n_fail++; $display("FAIL rst_error: got %b expected 0", error); end
        n_cmp++; if (retired !== 16'h0) begin n_fail++; $display("FAIL rst_retired: got %0d expected 0", retired); end
        n_cmp++; if (state_dbg !== 3'd0) begin n_fail++; $display("FAIL rst_state: got %0d expected 0", state_dbg); end
        apply_reset();
    endtask

    task automatic test_basic();
        apply_reset();
        load_word(4'd0, 24'h000010); load_word(4'd1, 24'h010004);
        load_word(4'd2, 24'h201000); load_word(4'd3, 24'hF00000);
        exp_q = '{24'h000010, 24'h010004, 24'h201000};
        resp_delay = 2; resp_en = 1'b1;
        run = 1'b1;
        wait_halted("basic", 100);
        n_cmp++; if (obs_q.size() != 3) begin n_fail++; $display("FAIL basic_count: got %0d issues expected 3", obs_q.size()); end
        for (int i = 0; i < 3 && i < obs_q.size(); i++) begin
            n_cmp++; if (obs_q[i] !== exp_q[i]) begin n_fail++; $display("FAIL basic_func%0d: got %h expected %h", i, obs_q[i], exp_q[i]); end
            n_cmp++; if (obs_pc_q[i] !== 4'(i)) begin n_fail++; $display("FAIL basic_pc%0d: got %0d expected %0d", i, obs_pc_q[i], i); end
        end
        if (obs_t_q.size() >= 2) begin
            n_cmp++; if (obs_t_q[1] - obs_t_q[0] != 4) begin n_fail++; $display("FAIL basic_gap: got %0d expected 4", obs_t_q[1] - obs_t_q[0]); end
        end
        n_cmp++; if (retired !== 16'd3) begin n_fail++; $display("FAIL basic_retired: got %0d expected 3", retired); end
        n_cmp++; if (pc !== 4'd3) begin n_fail++; $display("FAIL basic_halt_pc: got %0d expected 3", pc); end
        n_cmp++; if (error !== 1'b0) begin n_fail++; $display("FAIL basic_error: got %b expected 0", error); end
        repeat (2) @(negedge clk);
        n_cmp++; if (proc_start !== 1'b0) begin n_fail++; $display("FAIL basic_proc_start: got %b expected 0", proc_start); end
        run = 1'b0;
        repeat (2) @(negedge clk);
        n_cmp++; if (halted !== 1'b0) begin n_fail++; $display("FAIL basic_unhalt: got %b expected 0", halted); end
    endtask

    task automatic test_back_to_back();
        apply_reset();
        resp_delay = 1; resp_en = 1'b1;
        run = 1'b1;
        wait_halted("b2b", 100);
        n_cmp++; if (obs_t_q.size() != 3) begin n_fail++; $display("FAIL b2b_count: got %0d issues expected 3", obs_t_q.size()); end
        for (int i = 1; i < obs_t_q.size(); i++) begin
            n_cmp++; if (obs_t_q[i] - obs_t_q[i-1] != 3) begin n_fail++; $display("FAIL b2b_gap%0d: got %0d expected 3", i, obs_t_q[i] - obs_t_q[i-1]); end
        end
        n_cmp++; if (retired !== 16'd3) begin n_fail++; $display("FAIL b2b_retired: got %0d expected 3", retired); end
    endtask

    task automatic test_branch();
        logic [23:0]       prog [6];
        logic [ADDR_W-1:0] exp_pc [9];
        prog   = '{24'h030000, 24'h031111, 24'h032222, 24'h033333, 24'h600000, 24'hF00000};
        exp_pc = '{4'd0, 4'd1, 4'd2, 4'd3, 4'd4, 4'd1, 4'd2, 4'd3, 4'd4};
        apply_reset();
        for (int i = 0; i < 6; i++) load_word(4'(i), prog[i]);
        branch_target = 16'hFFF1;
        resp_delay = 2; resp_en = 1'b1;
        run = 1'b1;
        wait_obs("branch", 6, 100);
        branch_target = 16'hABC5;
        wait_halted("branch", 100);
        n_cmp++; if (obs_q.size() != 9) begin n_fail++; $display("FAIL branch_count: got %0d issues expected 9", obs_q.size()); end
        for (int i = 0; i < 9 && i < obs_q.size(); i++) begin
            n_cmp++; if (obs_pc_q[i] !== exp_pc[i]) begin n_fail++; $display("FAIL branch_pc%0d: got %0d expected %0d", i, obs_pc_q[i], exp_pc[i]); end
            n_cmp++; if (obs_q[i] !== prog[exp_pc[i]]) begin n_fail++; $display("FAIL branch_func%0d: got %h expected %h", i, obs_q[i], prog[exp_pc[i]]); end
        end
        n_cmp++; if (pc !== 4'd5) begin n_fail++; $display("FAIL branch_halt_pc: got %0d expected 5", pc); end
        n_cmp++; if (retired !== 16'd9) begin n_fail++; $display("FAIL branch_retired: got %0d expected 9", retired); end
        run = 1'b0;
        repeat (2) @(negedge clk);
    endtask

    task automatic test_wrap();
        apply_reset();
        for (int i = 0; i < 16; i++) load_word(4'(i), 24'h0A0000 | 24'(i << 8));
        resp_delay = 1; resp_en = 1'b1;
        run = 1'b1;
        wait_obs("wrap", 17, 200);
        run = 1'b0;
        wait_idle("wrap", 50);
        n_cmp++; if (obs_q.size() != 17) begin n_fail++; $display("FAIL wrap_count: got %0d issues expected 17", obs_q.size()); end
        if (obs_q.size() >= 17) begin
            n_cmp++; if (obs_pc_q[15] !== 4'd15) begin n_fail++; $display("FAIL wrap_pc15: got %0d expected 15", obs_pc_q[15]); end
            n_cmp++; if (obs_pc_q[16] !== 4'd0) begin n_fail++; $display("FAIL wrap_pc16: got %0d expected 0", obs_pc_q[16]); end
            n_cmp++; if (obs_q[15] !== 24'h0A0F00) begin n_fail++; $display("FAIL wrap_func15: got %h expected 0a0f00", obs_q[15]); end
            n_cmp++; if (obs_q[16] !== 24'h0A0000) begin n_fail++; $display("FAIL wrap_func16: got %h expected 0a0000", obs_q[16]); end
        end
        n_cmp++; if (pc !== 4'd1) begin n_fail++; $display("FAIL wrap_idle_pc: got %0d expected 1", pc); end
        n_cmp++; if (retired !== 16'd17) begin n_fail++; $display("FAIL wrap_retired: got %0d expected 17", retired); end
        n_cmp++; if (halted !== 1'b0) begin n_fail++; $display("FAIL wrap_halted: got %b expected 0", halted); end
    endtask

    task automatic test_run_drop_wait();
        apply_reset();
        load_word(4'd0, 24'h050000); load_word(4'd1, 24'h051111); load_word(4'd2, 24'hF00000);
        resp_delay = 5; resp_en = 1'b1;
        run = 1'b1;
        wait_obs("drop", 1, 50);
        @(negedge clk);
        run = 1'b0;
        n_cmp++; if (busy !== 1'b1) begin n_fail++; $display("FAIL drop_busy: got %b expected 1", busy); end
        wait_idle("drop", 30);
        n_cmp++; if (obs_q.size() != 1) begin n_fail++; $display("FAIL drop_count: got %0d issues expected 1", obs_q.size()); end
        n_cmp++; if (pc !== 4'd1) begin n_fail++; $display("FAIL drop_pc: got %0d expected 1", pc); end
        n_cmp++; if (retired !== 16'd1) begin n_fail++; $display("FAIL drop_retired: got %0d expected 1", retired); end
        run = 1'b1;
        wait_halted("drop_resume", 50);
        n_cmp++; if (obs_q.size() != 2) begin n_fail++; $display("FAIL resume_count: got %0d issues expected 2", obs_q.size()); end
        if (obs_q.size() >= 2) begin
            n_cmp++; if (obs_pc_q[1] !== 4'd1) begin n_fail++; $display("FAIL resume_pc: got %0d expected 1", obs_pc_q[1]); end
            n_cmp++; if (obs_q[1] !== 24'h051111) begin n_fail++; $display("FAIL resume_func: got %h expected 051111", obs_q[1]); end
        end
        run = 1'b0;
        repeat (2) @(negedge clk);
    endtask

    task automatic test_timeout();
        apply_reset();
        load_word(4'd0, 24'h070000); load_word(4'd1, 24'hF00000);
        run = 1'b1;
        wait_new_func("tmo", 20);
        repeat (TIMEOUT) @(negedge clk);
        n_cmp++; if (halted !== 1'b0 || error !== 1'b0) begin n_fail++; $display("FAIL tmo_early: halted=%b error=%b expected 0 0", halted, error); end
        @(negedge clk);
        n_cmp++; if (error !== 1'b1) begin n_fail++; $display("FAIL tmo_error: got %b expected 1", error); end
        n_cmp++; if (halted !== 1'b1) begin n_fail++; $display("FAIL tmo_halted: got %b expected 1", halted); end
        n_cmp++; if (pc !== 4'd0) begin n_fail++; $display("FAIL tmo_pc: got %0d expected 0", pc); end
        man_done = 1'b1;
        @(negedge clk);
        man_done = 1'b0;
        @(negedge clk);
        n_cmp++; if (retired !== 16'd0) begin n_fail++; $display("FAIL tmo_late_done: got %0d expected 0", retired); end
        run = 1'b0;
        repeat (2) @(negedge clk);
        n_cmp++; if (error !== 1'b1 || halted !== 1'b0) begin n_fail++; $display("FAIL tmo_sticky: error=%b halted=%b expected 1 0", error, halted); end

        apply_reset();
        run = 1'b1;
        wait_new_func("tmo_edge", 20);
        repeat (TIMEOUT) @(posedge clk);
        #1 man_done = 1'b1;
        @(posedge clk);
        #1 man_done = 1'b0;
        n_cmp++; if (error !== 1'b0) begin n_fail++; $display("FAIL tmo_edge_error: got %b expected 0", error); end
        n_cmp++; if (retired !== 16'd1) begin n_fail++; $display("FAIL tmo_edge_retired: got %0d expected 1", retired); end
        n_cmp++; if (pc !== 4'd1) begin n_fail++; $display("FAIL tmo_edge_pc: got %0d expected 1", pc); end
        wait_halted("tmo_edge", 20);
        n_cmp++; if (error !== 1'b0) begin n_fail++; $display("FAIL tmo_edge_halt_error: got %b expected 0", error); end
        run = 1'b0;
        repeat (2) @(negedge clk);
    endtask

    task automatic test_reset_mid_wait();
        apply_reset();
        load_word(4'd0, 24'h080000); load_word(4'd1, 24'hF00000);
        run = 1'b1;
        wait_new_func("rmw", 20);
        @(negedge clk);
        prog_we = 1'b1; prog_addr = 4'd0; prog_wdata = 24'hDEAD00;
        @(posedge clk);
        #2;
        n_cmp++; if (busy !== 1'b1 || proc_start !== 1'b1) begin n_fail++; $display("FAIL rmw_pre: busy=%b proc_start=%b expected 1 1", busy, proc_start); end
        reset = 1'b1; prog_we = 1'b0; run = 1'b0;
        #1;
        n_cmp++; if (busy !== 1'b0 || new_func !== 1'b0) begin n_fail++; $display("FAIL rmw_busy: busy=%b new_func=%b expected 0 0", busy, new_func); end
        n_cmp++; if (proc_start !== 1'b0) begin n_fail++; $display("FAIL rmw_proc_start: got %b expected 0", proc_start); end
        n_cmp++; if (func !== 24'h0 || pc !== 4'd0) begin n_fail++; $display("FAIL rmw_func_pc: func=%h pc=%0d expected 000000 0", func, pc); end
        @(negedge clk);
        reset = 1'b0;
        obs_q.delete(); obs_pc_q.delete(); obs_t_q.delete();
        resp_delay = 1; resp_en = 1'b1;
        run = 1'b1;
        wait_halted("rmw", 50);
        n_cmp++; if (obs_q.size() < 1) begin n_fail++; $display("FAIL rmw_count: got 0 issues expected 1"); end
        else begin
            n_cmp++; if (obs_q[0] !== 24'h080000) begin n_fail++; $display("FAIL rmw_ram: got %h expected 080000", obs_q[0]); end
        end
        run = 1'b0;
        repeat (2) @(negedge clk);
    endtask

    initial begin
        test_reset();
        test_basic();
        test_back_to_back();
        test_branch();
        test_wrap();
        test_run_drop_wait();
        test_timeout();
        test_reset_mid_wait();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
